// File: rtl/input_capture.sv
// Input-capture peripheral: picks one port_in line, synchronises it and reports
// period and active time in clk cycles over the user I/O bus, with optional irq.
module input_capture #(
  parameter logic [31:0] TIMEOUT     = 32'hFFFF_FFFF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        stall_o,
  output logic [2:0]  abort_o,
  input  logic [31:0] port_in,
  output logic        irq_o
);
  // state   | meaning
  // IDLE    | EN=0, counter held at 0
  // ARM     | waiting for the first active edge
  // MEASURE | counting cycles since the last active edge
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state, state_nxt;

  logic                   en, irq_en, pol;
  logic [4:0]             sel;
  logic                   valid, overrun, tout;
  logic [31:0]            period, high, count, count_nxt, rd_mux;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   lvl, lvl_d, act_edge, inact_edge;
  logic                   wr, rd, ctrl_wr, stat_wr, restart;
  logic                   cap_period, cap_high, hit_timeout;
  logic                   unused_ok;

  assign wr      = cs_i & write_i;
  assign rd      = cs_i & read_i;
  assign ctrl_wr = wr & (address_i[3:2] == 2'd0);
  assign stat_wr = wr & (address_i[3:2] == 2'd1);
  assign restart = ctrl_wr & en;

  assign stall_o   = 1'b0;
  assign abort_o   = 3'b000;
  assign unused_ok = ^{size_i, address_i[31:4], address_i[1:0], data_in[31:8]};

  // Polarity is applied to both the current and delayed sample so a POL change
  // by itself never looks like an edge.
  assign lvl        = sync_q[SYNC_STAGES-1] ^ pol;
  assign lvl_d      = sync_d ^ pol;
  assign act_edge   = lvl & ~lvl_d;
  assign inact_edge = ~lvl & lvl_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], port_in[sel]};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = ARM;
      ARM: begin
        if (!en)                       state_nxt = IDLE;
        else if (restart)              state_nxt = ARM;
        else if (act_edge)             state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!en)                       state_nxt = IDLE;
        else if (restart || count == TIMEOUT) state_nxt = ARM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timeout is tested before the increment, so the counter never wraps.
  always_comb begin
    count_nxt   = '0;
    cap_period  = 1'b0;
    cap_high    = 1'b0;
    hit_timeout = 1'b0;
    case (state)
      ARM: if (en && !restart && act_edge) count_nxt = 32'd1;
      MEASURE: begin
        if (en && !restart) begin
          if (count == TIMEOUT) begin
            hit_timeout = 1'b1;
          end else begin
            count_nxt = count + 32'd1;
            cap_high  = inact_edge;
            if (act_edge) begin
              cap_period = 1'b1;
              count_nxt  = 32'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (address_i[3:2])
      2'd0:    rd_mux = {24'h0, pol, sel, irq_en, en};
      2'd1:    rd_mux = {29'h0, tout, overrun, valid};
      2'd2:    rd_mux = period;
      default: rd_mux = high;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      sel      <= '0;
      pol      <= 1'b0;
      count    <= '0;
      period   <= '0;
      high     <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      tout     <= 1'b0;
      data_out <= '0;
    end else begin
      count <= count_nxt;
      if (ctrl_wr) begin
        en     <= data_in[0];
        irq_en <= data_in[1];
        sel    <= data_in[6:2];
        pol    <= data_in[7];
      end
      if (cap_period) period <= count;
      if (cap_high)   high   <= count;
      // status set beats a same-cycle write-one-to-clear
      valid    <= cap_period | (valid & ~(stat_wr & data_in[0]));
      overrun  <= (cap_period & valid) | (overrun & ~(stat_wr & data_in[1]));
      tout     <= hit_timeout | (tout & ~(stat_wr & data_in[2]));
      data_out <= rd ? rd_mux : '0;
    end
  end

  assign irq_o = irq_en & (valid | tout);

endmodule
